breath_meter: RTL and testbench

Receive-side companion to the LED breathing generator. It samples one gated light channel (a 1-bit PWM-style signal) in the `clk_div_i` domain and measures its duty cycle over fixed windows, reporting a quantised brightness level. It also measures the PWM period between rising edges and reports whether the light is brightening or dimming. It sits on the board-test path and drives the status LEDs/ILA, so the generator's breathing profile can be checked in hardware.

---
 rtl/breath_meter.sv | 80 ++++++++
 tb/tb_breath_meter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/breath_meter.sv
// breath_meter: measures duty-cycle level, brightness direction and rising-edge period of a PWM light channel.
// Define BREATH_METER_SYNC_EN to pass pwm_i through a two-flop synchroniser (2 clocks of latency).
module breath_meter #(
  parameter int WIN_LOG2 = 16,
  parameter int LEVEL_W  = 4,
  parameter int PERIOD_W = 32
) (
  input  logic                clk_div_i,
  input  logic                rst_n_i,
  input  logic                pwm_i,
  output logic [LEVEL_W-1:0]  level_o,
  output logic                level_valid_o,
  output logic [1:0]          dir_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o
);
  typedef enum logic {IDLE, ARMED} state_t;
  logic s, s_d, rise;
`ifdef BREATH_METER_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk_div_i or negedge rst_n_i)
    if (!rst_n_i) sync_q <= '0;
    else sync_q <= {sync_q[0], pwm_i};
  assign s = sync_q[1];
`else
  assign s = pwm_i;
`endif
  assign rise = s & ~s_d;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [WIN_LOG2:0]   hi_cnt, hi_sum, hi_shr;
  logic [LEVEL_W-1:0]  lvl;
  logic                win_end, have_lvl;
  // hi_sum folds in the current sample so the window's last cycle is counted
  always_comb begin
    win_end = &win_cnt;
    hi_sum  = hi_cnt + (WIN_LOG2+1)'(s);
    hi_shr  = hi_sum >> (WIN_LOG2 - LEVEL_W);
    lvl     = |hi_shr[WIN_LOG2:LEVEL_W] ? '1 : hi_shr[LEVEL_W-1:0];
  end
  always_ff @(posedge clk_div_i or negedge rst_n_i)
    if (!rst_n_i) begin
      s_d           <= 1'b0;
      win_cnt       <= '0;
      hi_cnt        <= '0;
      have_lvl      <= 1'b0;
      level_o       <= '0;
      level_valid_o <= 1'b0;
      dir_o         <= 2'b00;
    end else begin
      s_d           <= s;
      win_cnt       <= win_cnt + WIN_LOG2'(1);
      hi_cnt        <= win_end ? '0 : hi_sum;
      level_valid_o <= win_end;
      if (win_end) begin
        have_lvl <= 1'b1;
        level_o  <= lvl;
        dir_o    <= !have_lvl ? 2'b00 : (lvl > level_o) ? 2'b01 : (lvl < level_o) ? 2'b10 : 2'b00;
      end
    end
  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] per_cnt, per_nxt;
  logic                per_upd;
  always_comb begin
    state_nxt = (state == IDLE && rise) ? ARMED : state;
    per_upd   = (state == ARMED) && rise;
    per_nxt   = rise ? PERIOD_W'(1) : (state == ARMED && !(&per_cnt)) ? per_cnt + PERIOD_W'(1) : per_cnt;
  end
  always_ff @(posedge clk_div_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state          <= IDLE;
      per_cnt        <= '0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      per_cnt        <= per_nxt;
      period_valid_o <= per_upd;
      if (per_upd) period_o <= per_cnt;
    end
endmodule

// File: tb/tb_breath_meter.sv
// tb_breath_meter: randomized and directed checks of breath_meter against a window/edge-list reference model.
module tb_breath_meter;
`ifdef BREATH_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk_div_i = 1'b0, rst_n_i = 1'b0, pwm_i = 1'b0;
  logic [3:0] level_o;
  logic       level_valid_o, period_valid_o;
  logic [1:0] dir_o;
  logic [7:0] period_o;
  int checks = 0, failures = 0;
  breath_meter #(.WIN_LOG2(8), .LEVEL_W(4), .PERIOD_W(8)) dut (
    .clk_div_i(clk_div_i), .rst_n_i(rst_n_i), .pwm_i(pwm_i),
    .level_o(level_o), .level_valid_o(level_valid_o), .dir_o(dir_o),
    .period_o(period_o), .period_valid_o(period_valid_o)
  );
  always #5 clk_div_i = ~clk_div_i;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run time exceeded");
    $fatal(1, "timeout");
  end
  // reference model state: sample stream, window sum, list position of last rising edge
  logic pq[$];
  int n, win_sum, last_rise;
  logic prev_s, have;
  logic e_lv, e_pv;
  logic [3:0] e_lvl;
  logic [1:0] e_dir;
  logic [7:0] e_per;
  task automatic model_reset();
    pq.delete();
    n = 0; win_sum = 0; last_rise = -1; prev_s = 1'b0; have = 1'b0;
    e_lv = 1'b0; e_pv = 1'b0; e_lvl = '0; e_dir = 2'b00; e_per = '0;
  endtask
  task automatic do_reset();
    rst_n_i = 1'b0;
    pwm_i = 1'b0;
    repeat (2) @(posedge clk_div_i);
    @(negedge clk_div_i);
    rst_n_i = 1'b1;
    model_reset();
  endtask
  task automatic step(input logic b);
    logic sv;
    int lv, d;
    pwm_i = b;
    @(posedge clk_div_i); #1;
    pq.push_back(b);
    sv = (pq.size() > LAT) ? pq.pop_front() : 1'b0;
    win_sum += int'(sv);
    e_lv = 1'b0;
    e_pv = 1'b0;
    if (sv && !prev_s) begin
      if (last_rise >= 0) begin
        d = n - last_rise;
        e_pv = 1'b1;
        e_per = 8'(d > 255 ? 255 : d);
      end
      last_rise = n;
    end
    prev_s = sv;
    n++;
    if (n % 256 == 0) begin
      lv = win_sum / 16;
      if (lv > 15) lv = 15;
      e_dir = !have ? 2'b00 : (lv > int'(e_lvl)) ? 2'b01 : (lv < int'(e_lvl)) ? 2'b10 : 2'b00;
      e_lvl = 4'(lv);
      have = 1'b1;
      e_lv = 1'b1;
      win_sum = 0;
    end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({level_valid_o, level_o, dir_o, period_valid_o, period_o} !== 16'h0) begin
      failures++;
      $display("FAIL reset got=%h exp=0000", {level_valid_o, level_o, dir_o, period_valid_o, period_o});
    end
  endtask
  task automatic test_all_high();
    do_reset();
    for (int k = 0; k < 3 * 256; k++) begin
      step(1'b1);
      checks++;
      if ({level_valid_o, level_o, dir_o, period_valid_o, period_o} !== {e_lv, e_lvl, e_dir, e_pv, e_per}) begin
        failures++;
        $display("FAIL all_high cyc=%0d got=%h exp=%h", n, {level_valid_o, level_o, dir_o, period_valid_o, period_o}, {e_lv, e_lvl, e_dir, e_pv, e_per});
      end
    end
    checks++;
    if (level_o !== 4'd15) begin
      failures++;
      $display("FAIL all_high_level got=%0d exp=15", level_o);
    end
  endtask
  task automatic test_all_low();
    do_reset();
    for (int k = 0; k < 2 * 256; k++) begin
      step(1'b0);
      checks++;
      if ({level_valid_o, level_o, dir_o, period_valid_o, period_o} !== {e_lv, e_lvl, e_dir, e_pv, e_per}) begin
        failures++;
        $display("FAIL all_low cyc=%0d got=%h exp=%h", n, {level_valid_o, level_o, dir_o, period_valid_o, period_o}, {e_lv, e_lvl, e_dir, e_pv, e_per});
      end
    end
  endtask
  task automatic test_square();
    int first = -1;
    do_reset();
    for (int k = 0; k < 3 * 256; k++) begin
      step((k % 16) < 8);
      if (period_valid_o && first < 0) first = k + 1;
      checks++;
      if ({level_valid_o, level_o, dir_o, period_valid_o, period_o} !== {e_lv, e_lvl, e_dir, e_pv, e_per}) begin
        failures++;
        $display("FAIL square cyc=%0d got=%h exp=%h", n, {level_valid_o, level_o, dir_o, period_valid_o, period_o}, {e_lv, e_lvl, e_dir, e_pv, e_per});
      end
    end
    checks++;
    if (first !== 17 + LAT || period_o !== 8'd16 || level_o !== 4'd8) begin
      failures++;
      $display("FAIL square_timing got first=%0d per=%0d lvl=%0d exp first=%0d per=16 lvl=8", first, period_o, level_o, 17 + LAT);
    end
  endtask
  task automatic test_duty_step();
    int hi_len [3] = '{4, 8, 4};
    logic [3:0] lv_got [3];
    logic [1:0] dir_got [3];
    do_reset();
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 256; k++) begin
        step((k % 16) < hi_len[w]);
        if (level_valid_o) begin
          lv_got[w] = level_o;
          dir_got[w] = dir_o;
        end
        checks++;
        if ({level_valid_o, level_o, dir_o, period_valid_o, period_o} !== {e_lv, e_lvl, e_dir, e_pv, e_per}) begin
          failures++;
          $display("FAIL duty_step cyc=%0d got=%h exp=%h", n, {level_valid_o, level_o, dir_o, period_valid_o, period_o}, {e_lv, e_lvl, e_dir, e_pv, e_per});
        end
      end
    checks++;
    if ({lv_got[0], lv_got[1], lv_got[2], dir_got[0], dir_got[1], dir_got[2]} !== {4'd4, 4'd8, 4'd4, 2'b00, 2'b01, 2'b10}) begin
      failures++;
      $display("FAIL duty_step_levels got lvl=%0d,%0d,%0d dir=%b,%b,%b exp lvl=4,8,4 dir=00,01,10",
               lv_got[0], lv_got[1], lv_got[2], dir_got[0], dir_got[1], dir_got[2]);
    end
  endtask
  task automatic test_period_sat();
    do_reset();
    for (int k = 0; k < 310; k++) begin
      step(k == 0 || k >= 301);
      checks++;
      if ({level_valid_o, level_o, dir_o, period_valid_o, period_o} !== {e_lv, e_lvl, e_dir, e_pv, e_per}) begin
        failures++;
        $display("FAIL period_sat cyc=%0d got=%h exp=%h", n, {level_valid_o, level_o, dir_o, period_valid_o, period_o}, {e_lv, e_lvl, e_dir, e_pv, e_per});
      end
    end
    checks++;
    if (period_o !== 8'd255) begin
      failures++;
      $display("FAIL period_sat_value got=%0d exp=255", period_o);
    end
  endtask
  task automatic test_mid_reset();
    int first = -1;
    do_reset();
    for (int k = 0; k < 300; k++) step((k % 10) < 3);
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({level_valid_o, level_o, dir_o, period_valid_o, period_o} !== 16'h0) begin
      failures++;
      $display("FAIL mid_reset_clear got=%h exp=0000", {level_valid_o, level_o, dir_o, period_valid_o, period_o});
    end
    repeat (2) @(negedge clk_div_i);
    rst_n_i = 1'b1;
    model_reset();
    for (int k = 0; k < 300; k++) begin
      step((k % 10) < 6);
      if (level_valid_o && first < 0) first = k + 1;
      checks++;
      if ({level_valid_o, level_o, dir_o, period_valid_o, period_o} !== {e_lv, e_lvl, e_dir, e_pv, e_per}) begin
        failures++;
        $display("FAIL mid_reset cyc=%0d got=%h exp=%h", n, {level_valid_o, level_o, dir_o, period_valid_o, period_o}, {e_lv, e_lvl, e_dir, e_pv, e_per});
      end
    end
    checks++;
    if (first !== 256) begin
      failures++;
      $display("FAIL mid_reset_first_level got=%0d exp=256", first);
    end
  endtask
  task automatic test_random();
    logic b = 1'b0;
    int run = 0;
    do_reset();
    for (int k = 0; k < 4 * 256; k++) begin
      if (run == 0) begin
        b = ~b;
        run = (k % 256 < 128) ? $urandom_range(1, 12) : $urandom_range(1, 300);
      end
      run--;
      step(b);
      checks++;
      if ({level_valid_o, level_o, dir_o, period_valid_o, period_o} !== {e_lv, e_lvl, e_dir, e_pv, e_per}) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h", n, {level_valid_o, level_o, dir_o, period_valid_o, period_o}, {e_lv, e_lvl, e_dir, e_pv, e_per});
      end
    end
  endtask
  initial begin
    test_reset();
    test_all_high();
    test_all_low();
    test_square();
    test_duty_step();
    test_period_sat();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
